issue_hazard_ctrl: RTL and testbench

In-order issue controller feeding the Stage 1 decode register. It accepts instructions from the fetch side over a valid/ready handshake and tracks the destination registers of in-flight instructions in a scoreboard. When a read-after-write hazard exists it stalls the fetch side and presents a bubble to Stage 1. It sits between instruction fetch and the Stage 1 pipeline register.

---
 rtl/issue_hazard_ctrl_pkg.sv | 22 ++
 rtl/hazard_scoreboard.sv | 68 ++++++
 rtl/issue_hazard_ctrl.sv | 72 +++++++
 tb/tb_issue_hazard_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_hazard_ctrl_pkg.sv
// Shared definitions for the issue/hazard controller: instruction field
// positions, the bubble encoding and the scoreboard entry type.
package issue_hazard_ctrl_pkg;

  localparam int DEST_HI = 25;
  localparam int DEST_LO = 21;
  localparam int SRC1_HI = 20;
  localparam int SRC1_LO = 16;
  localparam int SRC2_HI = 15;
  localparam int SRC2_LO = 11;

  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO     = 5'd0;

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{v: 1'b0, dst: REG_ZERO};

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight destination registers with RAW compare.
// HAZARD_BYPASS_EN: drop the oldest entry from the compare (register file writes before reads).
module hazard_scoreboard
  import issue_hazard_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       push_i,
  input  logic [4:0] push_dst_i,
  input  logic [4:0] src1_i,
  input  logic [4:0] src2_i,
  output logic       hazard_o,
  output logic       busy_o
);

`ifdef HAZARD_BYPASS_EN
  localparam int CMP_N = PIPE_DEPTH - 1;
`else
  localparam int CMP_N = PIPE_DEPTH;
`endif

  sb_entry_t sb_q [PIPE_DEPTH];
  sb_entry_t sb_d [PIPE_DEPTH];

  // Entry 0 mirrors issue_instr; older instructions move one slot per edge.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    sb_d[0] = push_i ? '{v: 1'b1, dst: push_dst_i} : SB_EMPTY;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      sb_d[i] = sb_q[i-1];
    end
    if (clear_i) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        sb_d[i] = SB_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: the scoreboard is a handful of flops, not a RAM, so every entry is reset.
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        sb_q[i] <= SB_EMPTY;
      end
    end else begin
      sb_q <= sb_d;
    end
  end

  always_comb begin
    hazard_o = 1'b0;
    busy_o   = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      busy_o = busy_o | sb_q[i].v;
    end
    for (int i = 0; i < CMP_N; i++) begin
      if (sb_q[i].v && (sb_q[i].dst != REG_ZERO) &&
          ((sb_q[i].dst == src1_i) || (sb_q[i].dst == src2_i))) begin
        hazard_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_hazard_ctrl.sv
// In-order issue controller: fetch handshake, Stage 1 issue register, stall counter.
// HAZARD_BYPASS_EN (see hazard_scoreboard) shortens the dependent-pair stall by one cycle.
module issue_hazard_ctrl
  import issue_hazard_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int STALL_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [31:0]        instr_in,
  output logic               instr_ready,
  input  logic               flush,
  output logic [31:0]        issue_instr,
  output logic               issue_valid,
  output logic               busy,
  output logic [STALL_W-1:0] stall_count
);

  logic               hazard;
  logic               transfer;
  logic               stall_inc;
  logic [31:0]        issue_instr_q, issue_instr_d;
  logic               issue_valid_q, issue_valid_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  hazard_scoreboard #(
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (flush),
    .push_i     (transfer),
    .push_dst_i (instr_in[DEST_HI:DEST_LO]),
    .src1_i     (instr_in[SRC1_HI:SRC1_LO]),
    .src2_i     (instr_in[SRC2_HI:SRC2_LO]),
    .hazard_o   (hazard),
    .busy_o     (busy)
  );

  // Ready never looks at instr_valid, so fetch can rely on it as a pure grant.
  assign instr_ready = !rst && !flush && !hazard;
  assign transfer    = instr_valid && instr_ready;
  assign stall_inc   = instr_valid && hazard && !flush;

  always_comb begin
    issue_instr_d = transfer ? instr_in : BUBBLE_INSTR;
    issue_valid_d = transfer;
    stall_d       = stall_q;
    if (stall_inc && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_instr_q <= BUBBLE_INSTR;
      issue_valid_q <= 1'b0;
      stall_q       <= '0;
    end else begin
      issue_instr_q <= issue_instr_d;
      issue_valid_q <= issue_valid_d;
      stall_q       <= stall_d;
    end
  end

  assign issue_instr = issue_instr_q;
  assign issue_valid = issue_valid_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Self-checking bench for issue_hazard_ctrl using a timestamp-based reference model.
module tb_issue_hazard_ctrl;

  localparam int PIPE_DEPTH = 3;
`ifdef HAZARD_BYPASS_EN
  localparam int WIN = PIPE_DEPTH - 1;
`else
  localparam int WIN = PIPE_DEPTH;
`endif
  localparam int NEVER = -1000;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr_in;
  logic        flush;
  logic        instr_ready, instr_ready4;
  logic [31:0] issue_instr, issue_instr4;
  logic        issue_valid, issue_valid4;
  logic        busy, busy4;
  logic [15:0] stall_count;
  logic [3:0]  stall_count4;

  int checks;
  int failures;

  // Model: edge counter and the edge at which each register was last issued as a destination.
  int          ecnt;
  int          last_wr [32];
  int          last_any;
  logic [31:0] m_issue;
  logic        m_valid;
  int          m_stall16;
  int          m_stall4;

  issue_hazard_ctrl #(.PIPE_DEPTH(PIPE_DEPTH), .STALL_W(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_in(instr_in),
    .instr_ready(instr_ready), .flush(flush), .issue_instr(issue_instr),
    .issue_valid(issue_valid), .busy(busy), .stall_count(stall_count)
  );

  issue_hazard_ctrl #(.PIPE_DEPTH(PIPE_DEPTH), .STALL_W(4)) dut_sat (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_in(instr_in),
    .instr_ready(instr_ready4), .flush(flush), .issue_instr(issue_instr4),
    .issue_valid(issue_valid4), .busy(busy4), .stall_count(stall_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input int d, input int s1, input int s2);
    logic [4:0] dd, ss1, ss2;
    dd = 5'(d); ss1 = 5'(s1); ss2 = 5'(s2);
    return {6'b101010, dd, ss1, ss2, 11'h155};
  endfunction

  function automatic logic [31:0] mk_rand();
    logic [5:0]  op;
    logic [10:0] lo;
    op = 6'($urandom);
    lo = 11'($urandom);
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), lo};
  endfunction

  // A source conflicts while its producer was issued within the last WIN edges.
  function automatic bit m_hazard(input logic [31:0] ins);
    int s1, s2;
    s1 = int'(ins[20:16]);
    s2 = int'(ins[15:11]);
    if (s1 != 0 && (ecnt + 1 - last_wr[s1]) <= WIN) return 1'b1;
    if (s2 != 0 && (ecnt + 1 - last_wr[s2]) <= WIN) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    return !rst && !flush && !m_hazard(instr_in);
  endfunction

  function automatic bit m_busy();
    return (ecnt - last_any) <= PIPE_DEPTH - 1;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 32; r++) last_wr[r] = NEVER;
    last_any = NEVER;
  endtask

  // Advance one clock: update the model at the rising edge, return at the falling edge.
  task automatic tick();
    bit hz, acc;
    hz  = m_hazard(instr_in);
    acc = instr_valid && m_ready();
    @(posedge clk);
    ecnt++;
    if (rst) begin
      m_clear();
      m_issue   = 32'h0;
      m_valid   = 1'b0;
      m_stall16 = 0;
      m_stall4  = 0;
    end else begin
      if (instr_valid && hz && !flush) begin
        if (m_stall16 < 65535) m_stall16++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (flush) m_clear();
      if (acc) begin
        last_wr[int'(instr_in[25:21])] = ecnt;
        last_any = ecnt;
        m_issue  = instr_in;
        m_valid  = 1'b1;
      end else begin
        m_issue = 32'h0;
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    flush       = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b1; flush = 1'b0; instr_in = mk(1, 2, 3);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (instr_ready !== 1'b0) begin
        failures++; $display("FAIL reset_ready cycle %0d: got %b want 0", c, instr_ready);
      end
      tick();
    end
    checks++;
    if (issue_instr !== 32'h0 || issue_valid !== 1'b0) begin
      failures++; $display("FAIL reset_issue: got %h/%b want 00000000/0", issue_instr, issue_valid);
    end
    checks++;
    if (stall_count !== 16'h0 || stall_count4 !== 4'h0) begin
      failures++; $display("FAIL reset_stall: got %0d/%0d want 0/0", stall_count, stall_count4);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_independent();
    logic [31:0] seq [3];
    logic [15:0] s0;
    seq[0] = mk(1, 2, 3); seq[1] = mk(4, 5, 6); seq[2] = mk(7, 8, 9);
    s0 = stall_count;
    for (int i = 0; i < 3; i++) begin
      instr_valid = 1'b1; instr_in = seq[i];
      #1;
      checks++;
      if (instr_ready !== 1'b1) begin
        failures++; $display("FAIL indep_ready[%0d]: got %b want 1", i, instr_ready);
      end
      tick();
      checks++;
      if (issue_instr !== seq[i] || issue_valid !== 1'b1) begin
        failures++;
        $display("FAIL indep_issue[%0d]: got %h/%b want %h/1", i, issue_instr, issue_valid, seq[i]);
      end
    end
    checks++;
    if (stall_count !== s0) begin
      failures++; $display("FAIL indep_stall: got %0d want %0d", stall_count, s0);
    end
    idle(PIPE_DEPTH + 1);
  endtask

  task automatic test_raw_hazard();
    logic [31:0] prod, cons;
    logic [15:0] s0;
    int bubbles, edges;
    bit accepted;
    prod = mk(5, 1, 2); cons = mk(6, 5, 3);
    s0 = stall_count;
    instr_valid = 1'b1; instr_in = prod;
    tick();
    instr_in = cons;
    bubbles = 0; edges = 0; accepted = 0;
    while (!accepted && edges < 10) begin
      #1;
      tick();
      edges++;
      if (issue_valid === 1'b1) accepted = 1;
      else bubbles++;
    end
    instr_valid = 1'b0;
    checks++;
    if (!accepted) begin
      failures++; $display("FAIL raw_timeout: consumer not issued within 10 edges");
    end
    checks++;
    if (bubbles != WIN || edges != WIN + 1) begin
      failures++;
      $display("FAIL raw_bubbles: got %0d bubbles/edge %0d want %0d/%0d", bubbles, edges, WIN, WIN + 1);
    end
    checks++;
    if (issue_instr !== cons) begin
      failures++; $display("FAIL raw_issue: got %h want %h", issue_instr, cons);
    end
    checks++;
    if (stall_count - s0 !== 16'(WIN)) begin
      failures++; $display("FAIL raw_stall: got %0d want %0d", stall_count - s0, WIN);
    end
    idle(PIPE_DEPTH + 1);
  endtask

  task automatic test_r0_dest();
    logic [31:0] a, b;
    logic [15:0] s0;
    a = mk(0, 1, 2); b = mk(3, 0, 0);
    s0 = stall_count;
    instr_valid = 1'b1; instr_in = a;
    tick();
    instr_in = b;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++; $display("FAIL r0_ready: got %b want 1", instr_ready);
    end
    tick();
    checks++;
    if (issue_instr !== b || issue_valid !== 1'b1 || stall_count !== s0) begin
      failures++;
      $display("FAIL r0_issue: got %h/%b stall %0d want %h/1 stall %0d",
               issue_instr, issue_valid, stall_count, b, s0);
    end
    idle(PIPE_DEPTH + 1);
  endtask

  task automatic test_flush();
    logic [31:0] prod, cons;
    logic [15:0] s0;
    prod = mk(5, 1, 2); cons = mk(6, 5, 3);
    s0 = stall_count;
    instr_valid = 1'b1; instr_in = prod;
    tick();
    instr_in = cons; flush = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b0) begin
      failures++; $display("FAIL flush_ready: got %b want 0", instr_ready);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (issue_valid !== 1'b0 || issue_instr !== 32'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_bubble: got %h/%b busy %b want 00000000/0 busy 0", issue_instr, issue_valid, busy);
    end
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++; $display("FAIL flush_ready_after: got %b want 1", instr_ready);
    end
    tick();
    instr_valid = 1'b0;
    checks++;
    if (issue_instr !== cons || issue_valid !== 1'b1 || stall_count !== s0) begin
      failures++;
      $display("FAIL flush_consumer: got %h/%b stall %0d want %h/1 stall %0d",
               issue_instr, issue_valid, stall_count, cons, s0);
    end
    idle(PIPE_DEPTH + 1);
  endtask

  task automatic test_saturation();
    int d;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d = 1;
    instr_valid = 1'b1; instr_in = mk(1, 0, 0);
    for (int c = 0; c < 45; c++) begin
      tick();
      checks++;
      if (stall_count4 !== 4'(m_stall4)) begin
        failures++; $display("FAIL sat_track cycle %0d: got %0d want %0d", c, stall_count4, m_stall4);
      end
      if (m_valid && m_issue == instr_in) begin
        instr_in = mk((d % 7) + 1, d, d);
        d = (d % 7) + 1;
      end
    end
    instr_valid = 1'b0;
    checks++;
    if (stall_count4 !== 4'hF) begin
      failures++; $display("FAIL sat_final: got %h want f", stall_count4);
    end
    checks++;
    if (stall_count !== 16'(m_stall16)) begin
      failures++; $display("FAIL sat_wide: got %0d want %0d", stall_count, m_stall16);
    end
    idle(PIPE_DEPTH + 1);
  endtask

  task automatic test_random();
    bit acc;
    acc = 1'b1;
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 19) == 0);
      if (!instr_valid || acc) begin
        instr_valid = ($urandom_range(0, 3) != 0);
        instr_in    = mk_rand();
      end
      #1;
      acc = instr_valid && m_ready();
      checks++;
      if (instr_ready !== m_ready()) begin
        failures++; $display("FAIL rand_ready cycle %0d: got %b want %b", c, instr_ready, m_ready());
      end
      tick();
      checks++;
      if (issue_instr !== m_issue || issue_valid !== m_valid) begin
        failures++;
        $display("FAIL rand_issue cycle %0d: got %h/%b want %h/%b", c, issue_instr, issue_valid, m_issue, m_valid);
      end
      checks++;
      if (busy !== m_busy()) begin
        failures++; $display("FAIL rand_busy cycle %0d: got %b want %b", c, busy, m_busy());
      end
      checks++;
      if (stall_count !== 16'(m_stall16) || stall_count4 !== 4'(m_stall4)) begin
        failures++;
        $display("FAIL rand_stall cycle %0d: got %0d/%0d want %0d/%0d",
                 c, stall_count, stall_count4, m_stall16, m_stall4);
      end
    end
    rst = 1'b0;
    idle(PIPE_DEPTH + 1);
  endtask

  initial begin
    checks = 0; failures = 0;
    ecnt = 0; m_clear();
    m_issue = 32'h0; m_valid = 1'b0; m_stall16 = 0; m_stall4 = 0;
    rst = 1'b1; instr_valid = 1'b0; instr_in = 32'h0; flush = 1'b0;
    test_reset();
    test_independent();
    test_raw_hazard();
    test_r0_dest();
    test_flush();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
